// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL phase sequencer: FSM states,
// config-word field geometry, status bit layout and the single-step helper.
package pll_seq_pkg;

  localparam int FIELD_W  = 4;
  localparam int N_FIELDS = 8;
  localparam int CFG_W    = FIELD_W * N_FIELDS;

  localparam int STAT_ERROR_BIT   = 31;
  localparam int STAT_OVERRUN_BIT = 30;
  localparam int STAT_BUSY_BIT    = 29;
  localparam int STAT_LOCKED_BIT  = 28;
  localparam int STAT_CLR         = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEP     = 2'd1,
    SETTLE   = 2'd2,
    WAITLOCK = 2'd3
  } seq_state_e;

  // Moves one unsigned field a single code toward its target, never wrapping.
  function automatic logic [FIELD_W-1:0] step_toward(input logic [FIELD_W-1:0] cur,
                                                     input logic [FIELD_W-1:0] tgt);
    logic [FIELD_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + 1'b1;
    end else if (cur > tgt) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pll_wait_timer.sv
// Loadable down-counter shared by the settle delay and the lock timeout.
// Load with (interval - 1); expired is high in the last cycle of the interval.
module pll_wait_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/pll_phase_sequencer.sv
// Walks the live PLL dynamic-config word toward a software target one code per
// field per step, waiting for settle and re-lock between steps.
module pll_phase_sequencer
  import pll_seq_pkg::*;
#(
  parameter logic [7:0]  ADDR_CTRL     = 8'hC4,
  parameter logic [7:0]  ADDR_STAT     = 8'hC5,
  parameter logic [31:0] INIT_CFG      = 32'h8408_0000,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000
) (
  input  logic        MCLK,
  input  logic        rst,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  input  logic        locked,
  output logic [31:0] CfgOut,
  output logic        busy,
  output logic        error
);

  seq_state_e       state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CFG_W-1:0] target_q, target_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             error_q, error_d;
  logic             overrun_q, overrun_d;

  logic [CFG_W-1:0] cfg_stepped;
  logic             timer_load;
  logic [15:0]      timer_val;
  logic             timer_expired;
  logic             ctrl_wr;
  logic             stat_clr;
  logic [31:0]      stat_word;

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
    assign cfg_stepped[i*FIELD_W +: FIELD_W] =
      step_toward(cfg_q[i*FIELD_W +: FIELD_W], target_q[i*FIELD_W +: FIELD_W]);
  end

  pll_wait_timer #(.W(16)) u_timer (
    .clk      (MCLK),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign ctrl_wr  = Write && (Address == ADDR_CTRL);
  assign stat_clr = Write && (Address == ADDR_STAT) && DataIn[STAT_CLR];

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    error_d    = error_q;
    overrun_d  = overrun_q;
    timer_load = 1'b0;
    timer_val  = 16'd0;

    if (stat_clr) begin
      error_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ctrl_wr) begin
          target_d   = DataIn;
          step_cnt_d = 16'd0;
          if (DataIn != cfg_q) begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        cfg_d      = cfg_stepped;
        step_cnt_d = (step_cnt_q == 16'hFFFF) ? step_cnt_q : step_cnt_q + 16'd1;
        timer_load = 1'b1;
        timer_val  = SETTLE_CYCLES - 16'd1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          timer_val  = LOCK_TIMEOUT - 16'd1;
          state_d    = WAITLOCK;
        end
      end
      WAITLOCK: begin
        // A lock seen in the final timeout cycle still counts as success.
        if (locked) begin
          state_d = (cfg_q == target_q) ? IDLE : STEP;
        end else if (timer_expired) begin
          error_d  = 1'b1;
          target_d = cfg_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ctrl_wr && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= INIT_CFG;
      target_q   <= INIT_CFG;
      step_cnt_q <= 16'd0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      error_q    <= error_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    stat_word                   = 32'd0;
    stat_word[STAT_ERROR_BIT]   = error_q;
    stat_word[STAT_OVERRUN_BIT] = overrun_q;
    stat_word[STAT_BUSY_BIT]    = busy;
    stat_word[STAT_LOCKED_BIT]  = locked;
    stat_word[15:0]             = step_cnt_q;
  end

  always_comb begin
    DataOut = 32'd0;
    if (Read && (Address == ADDR_CTRL)) begin
      DataOut = cfg_q;
    end else if (Read && (Address == ADDR_STAT)) begin
      DataOut = stat_word;
    end
  end

  assign CfgOut = cfg_q;
  assign busy   = (state_q != IDLE);
  assign error  = error_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Randomized self-checking bench for pll_phase_sequencer against a
// transaction-level model of the stepping rules and per-step timing.
module tb_pll_phase_sequencer;

  localparam logic [7:0]  ADDR_CTRL = 8'hC4;
  localparam logic [7:0]  ADDR_STAT = 8'hC5;
  localparam logic [31:0] INIT_CFG  = 32'h8408_0000;
  localparam int          SETTLE    = 4;
  localparam int          TIMEOUT   = 8;

  logic        MCLK;
  logic        rst;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  logic        locked;
  logic [31:0] CfgOut;
  logic        busy;
  logic        error;

  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [31:0] modelCfg;

  pll_phase_sequencer #(
    .ADDR_CTRL     (ADDR_CTRL),
    .ADDR_STAT     (ADDR_STAT),
    .INIT_CFG      (INIT_CFG),
    .SETTLE_CYCLES (16'(SETTLE)),
    .LOCK_TIMEOUT  (16'(TIMEOUT))
  ) dut (
    .MCLK    (MCLK),
    .rst     (rst),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Address (Address),
    .Read    (Read),
    .Write   (Write),
    .locked  (locked),
    .CfgOut  (CfgOut),
    .busy    (busy),
    .error   (error)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus write spanning one cycle; a simultaneous read captures the pre-write value.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data,
                               output logic [31:0] preRead);
    Address = addr;
    DataIn  = data;
    Write   = 1'b1;
    Read    = 1'b1;
    #1;
    preRead = DataOut;
    Read    = 1'b0;
    @(negedge MCLK);
    Write   = 1'b0;
    Address = 8'h00;
  endtask

  task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
    Address = addr;
    Read    = 1'b1;
    #1;
    data    = DataOut;
    Read    = 1'b0;
    Address = 8'h00;
  endtask

  function automatic logic [31:0] modelStep(input logic [31:0] cur, input logic [31:0] tgt);
    logic [31:0] res;
    int c;
    int t;
    res = 32'd0;
    for (int i = 0; i < 8; i++) begin
      c = int'((cur >> (4 * i)) & 32'hF);
      t = int'((tgt >> (4 * i)) & 32'hF);
      if (c < t) c = c + 1;
      else if (c > t) c = c - 1;
      res = res | (32'(c) << (4 * i));
    end
    return res;
  endfunction

  function automatic int maxDist(input logic [31:0] a, input logic [31:0] b);
    int m;
    int x;
    int y;
    int d;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      x = int'((a >> (4 * i)) & 32'hF);
      y = int'((b >> (4 * i)) & 32'hF);
      d = (x > y) ? x - y : y - x;
      if (d > m) m = d;
    end
    return m;
  endfunction

  // Runs a full sequence: STEP at s_k, CfgOut updated from s_k+1, SETTLE for
  // SETTLE cycles, WAITLOCK from s_k+1+SETTLE, lock pulse after a chosen delay.
  task automatic runSequence(input logic [31:0] tgt, input bit randomLock, input bit inject);
    logic [31:0] startCfg;
    logic [31:0] expCfg;
    logic [31:0] rd;
    int          d;
    int          steps;
    startCfg = modelCfg;
    applyStimulus(ADDR_CTRL, tgt, rd);
    checkOutput("preWriteRead", rd, startCfg);
    if (tgt == startCfg) begin
      checkOutput("noopBusy", 32'(busy), 32'd0);
      @(negedge MCLK);
      checkOutput("noopBusyLater", 32'(busy), 32'd0);
      readReg(ADDR_STAT, rd);
      checkOutput("noopStat", rd, {3'b000, locked, 28'd0});
      return;
    end
    checkOutput("startBusy", 32'(busy), 32'd1);
    checkOutput("startCfgHold", CfgOut, startCfg);
    expCfg = startCfg;
    steps  = 0;
    while (expCfg != tgt && steps < 16) begin
      expCfg = modelStep(expCfg, tgt);
      steps++;
      checkOutput("stepBusy", 32'(busy), 32'd1);
      locked = randomLock ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge MCLK);
      checkOutput("stepCfg", CfgOut, expCfg);
      for (int i = 0; i < SETTLE; i++) begin
        locked = randomLock ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inject && steps == 1 && i == 0) begin
          Write   = 1'b1;
          Address = ADDR_CTRL;
          DataIn  = ~tgt;
        end else begin
          Write   = 1'b0;
          Address = 8'h00;
        end
        @(negedge MCLK);
      end
      Write = 1'b0;
      checkOutput("waitBusy", 32'(busy), 32'd1);
      d = 0;
      if (randomLock) begin
        d = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT - 1));
      end
      for (int j = 0; j < d; j++) begin
        locked = 1'b0;
        @(negedge MCLK);
      end
      locked = 1'b1;
      @(negedge MCLK);
    end
    locked = 1'b1;
    checkOutput("doneBusy", 32'(busy), 32'd0);
    checkOutput("doneCfg", CfgOut, tgt);
    readReg(ADDR_STAT, rd);
    checkOutput("doneStat", rd, {1'b0, inject, 1'b0, 1'b1, 12'd0, 16'(maxDist(startCfg, tgt))});
    modelCfg = tgt;
    if (inject) begin
      applyStimulus(ADDR_STAT, 32'h1, rd);
      readReg(ADDR_STAT, rd);
      checkOutput("overrunClr", rd, {3'b000, 1'b1, 12'd0, 16'(maxDist(startCfg, tgt))});
    end
  endtask

  // Starts a sequence and withholds lock so the first WAITLOCK times out.
  task automatic runTimeout(input logic [31:0] tgt, input bit doClear);
    logic [31:0] exp1;
    logic [31:0] rd;
    exp1   = modelStep(modelCfg, tgt);
    locked = 1'b0;
    applyStimulus(ADDR_CTRL, tgt, rd);
    @(negedge MCLK);
    checkOutput("toStepCfg", CfgOut, exp1);
    repeat (SETTLE) @(negedge MCLK);
    repeat (TIMEOUT - 1) @(negedge MCLK);
    checkOutput("toErrBefore", 32'(error), 32'd0);
    checkOutput("toBusyBefore", 32'(busy), 32'd1);
    @(negedge MCLK);
    checkOutput("toErr", 32'(error), 32'd1);
    checkOutput("toBusy", 32'(busy), 32'd0);
    checkOutput("toCfgFrozen", CfgOut, exp1);
    readReg(ADDR_STAT, rd);
    checkOutput("toStat", rd, 32'h8000_0001);
    modelCfg = exp1;
    applyStimulus(ADDR_STAT, 32'h2, rd);
    checkOutput("toNoClear", 32'(error), 32'd1);
    if (doClear) begin
      applyStimulus(ADDR_STAT, 32'h1, rd);
      checkOutput("toClear", 32'(error), 32'd0);
      locked = 1'b1;
      runSequence(exp1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] tgt;
    rst     = 1'b1;
    Read    = 1'b0;
    Write   = 1'b0;
    Address = 8'h00;
    DataIn  = 32'd0;
    locked  = 1'b0;
    repeat (3) @(negedge MCLK);
    rst = 1'b0;
    @(negedge MCLK);
    modelCfg = INIT_CFG;

    checkOutput("rstCfg", CfgOut, INIT_CFG);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstErr", 32'(error), 32'd0);
    readReg(ADDR_STAT, rd);
    checkOutput("rstStatUnlocked", rd, 32'h0000_0000);
    locked = 1'b1;
    readReg(ADDR_STAT, rd);
    checkOutput("rstStatLocked", rd, 32'h1000_0000);
    readReg(ADDR_CTRL, rd);
    checkOutput("rstCtrlRead", rd, INIT_CFG);
    Address = ADDR_CTRL;
    #1;
    checkOutput("idleBusZero", DataOut, 32'd0);
    Address = 8'h00;
    readReg(8'hC6, rd);
    checkOutput("unmappedRead", rd, 32'd0);

    runSequence(32'h8408_0003, 1'b0, 1'b0);
    runSequence(INIT_CFG, 1'b0, 1'b0);
    runSequence(32'h8008_0000, 1'b0, 1'b0);
    runSequence(32'h8008_0000, 1'b0, 1'b0);

    runTimeout(32'h8008_0003, 1'b1);
    runSequence(32'h0F0F_F0F0, 1'b1, 1'b1);

    runTimeout(32'h1234_5678, 1'b0);
    locked = 1'b0;
    applyStimulus(ADDR_CTRL, 32'hFFFF_FFFF, rd);
    @(negedge MCLK);
    @(negedge MCLK);
    rst = 1'b1;
    @(negedge MCLK);
    rst = 1'b0;
    checkOutput("midRstCfg", CfgOut, INIT_CFG);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstErr", 32'(error), 32'd0);
    readReg(ADDR_STAT, rd);
    checkOutput("midRstStat", rd, 32'h0000_0000);
    modelCfg = INIT_CFG;
    locked   = 1'b1;

    for (int n = 0; n < 20; n++) begin
      tgt = $urandom;
      if ($urandom_range(0, 5) == 0) tgt = modelCfg;
      runSequence(tgt, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
